// File: rtl/notch_pkg.sv
// Shared definitions for the notch filter front end: address width default,
// sample word size and the block-fetch state encoding.
package notch_pkg;
   localparam int ADDR_W_DEFAULT = 24;
   localparam int WORD_BYTES     = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_DONE
   } fetch_state_t;
endpackage

// File: rtl/notch_sample_fifo.sv
// Synchronous show-ahead FIFO, 32 bits wide: rd_data presents the head word
// whenever the FIFO is not empty, and reads 0 when empty.
module sample_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   output logic [31:0]   rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   used
);
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_wr, do_rd;

   assign empty = (used == '0);
   assign full  = (used == (AW+1)'(DEPTH));
   assign do_rd = rd_en && !empty;
   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
   assign do_wr = wr_en && (!full || do_rd);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         used <= used + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/notch_sample_fetch.sv
// Streams a block of 32-bit samples from SDRAM over a pipelined Avalon-MM read
// master into a show-ahead FIFO, never issuing a read it could not store.
module notch_sample_fetch
   import notch_pkg::*;
#(
   parameter int ADDR_W          = ADDR_W_DEFAULT,
   parameter int FIFO_DEPTH      = 16,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [31:0]       num_samples,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] sdaddress,
   output logic              sdread,
   input  logic [31:0]       sdreaddata,
   input  logic              sdreaddatavalid,
   input  logic              sdwaitrequest,
   output logic [31:0]       sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic [31:0]       received_count,
   output logic [31:0]       discard_count
);
   localparam int UW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   fetch_state_t   state, state_nx;
   logic [31:0]    remaining;
   logic [OW-1:0]  outstanding;
   logic [UW-1:0]  fifo_used;
   logic           fifo_empty, fifo_full;
   logic           room, accept, beat, pop, stray;

   // Every in-flight read already owns a FIFO slot, so returns can never overflow.
   assign room   = ((32'(outstanding) + 32'(fifo_used)) < 32'(FIFO_DEPTH)) &&
                   (32'(outstanding) < 32'(MAX_OUTSTANDING));
   assign accept = sdread && !sdwaitrequest;
   assign beat   = sdreaddatavalid && (state == ST_FETCH || state == ST_DRAIN);
   assign stray  = sdreaddatavalid && (state == ST_IDLE || state == ST_DONE);
   assign pop    = sample_valid && sample_ready;
   assign sample_valid = !fifo_empty;

   always_comb begin
      state_nx = state;
      sdread   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         ST_IDLE:  if (start) state_nx = (num_samples == '0) ? ST_DONE : ST_FETCH;
         ST_FETCH: begin
            busy   = 1'b1;
            sdread = room;
            if (accept && remaining == 32'd1) state_nx = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (outstanding == '0 && !beat &&
                (fifo_empty || (fifo_used == UW'(1) && pop)))
               state_nx = ST_DONE;
         end
         ST_DONE: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         sdaddress      <= '0;
         remaining      <= '0;
         outstanding    <= '0;
         received_count <= '0;
         discard_count  <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && start) begin
            sdaddress      <= base_addr & ~ADDR_W'(3);
            remaining      <= num_samples;
            received_count <= '0;
         end
         if (accept) begin
            sdaddress <= sdaddress + ADDR_W'(WORD_BYTES);
            remaining <= remaining - 32'd1;
         end
         case ({accept, beat})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: outstanding <= outstanding;
         endcase
         if (beat)  received_count <= received_count + 32'd1;
         if (stray) discard_count  <= discard_count + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) assert (!(beat && fifo_full && !pop));
   end

   sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (beat),
      .wr_data (sdreaddata),
      .rd_en   (pop),
      .rd_data (sample_data),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .used    (fifo_used)
   );
endmodule

// File: tb/tb_notch_sample_fetch.sv
// Directed bench for notch_sample_fetch with a behavioural Avalon read slave
// (2-cycle latency, optional hold of returns) returning {8'hC3, address}.
module tb_notch_sample_fetch;
   logic        clk = 1'b0;
   logic        reset, start, sdread, sdreaddatavalid, sdwaitrequest;
   logic        busy, done, sample_valid, sample_ready;
   logic [23:0] base_addr, sdaddress;
   logic [31:0] num_samples, sdreaddata, sample_data, received_count, discard_count;

   int tests = 0;
   int failed = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic hold = 1'b0;
   logic [23:0] pend_a[$];
   int          pend_t[$];
   logic [23:0] issued[$];
   logic [31:0] got[$];

   notch_sample_fetch dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .num_samples(num_samples), .busy(busy), .done(done),
      .sdaddress(sdaddress), .sdread(sdread), .sdreaddata(sdreaddata),
      .sdreaddatavalid(sdreaddatavalid), .sdwaitrequest(sdwaitrequest),
      .sample_data(sample_data), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .received_count(received_count),
      .discard_count(discard_count)
   );

   always #5 clk = ~clk;

   // Slave and monitors run on the falling edge, between stimulus updates.
   always @(negedge clk) begin
      cyc++;
      sdreaddatavalid = 1'b0;
      sdreaddata      = 32'h0;
      if (pend_a.size() > 0 && !hold && pend_t[0] <= cyc) begin
         sdreaddatavalid = 1'b1;
         sdreaddata      = {8'hC3, pend_a[0]};
         pend_a.delete(0);
         pend_t.delete(0);
      end
      if (sdread && !sdwaitrequest && !reset) begin
         pend_a.push_back(sdaddress);
         pend_t.push_back(cyc + 2);
         issued.push_back(sdaddress);
      end
      if (sample_valid && sample_ready && !reset) got.push_back(sample_data);
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go(input logic [23:0] b, input logic [31:0] n);
      base_addr = b; num_samples = n; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int maxc);
      int n = 0;
      while (!done && n < maxc) begin
         step();
         n++;
      end
      check(tag, {31'h0, done}, 32'h1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sdread"}, {31'h0, sdread}, 32'h0);
      check({tag, "_sdaddress"}, {8'h0, sdaddress}, 32'h0);
      check({tag, "_busy"}, {31'h0, busy}, 32'h0);
      check({tag, "_done"}, {31'h0, done}, 32'h0);
      check({tag, "_valid"}, {31'h0, sample_valid}, 32'h0);
      check({tag, "_data"}, sample_data, 32'h0);
      check({tag, "_received"}, received_count, 32'h0);
      check({tag, "_discard"}, discard_count, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i0, g0, d0;
      logic [23:0] exp_a1[5];
      logic [23:0] exp_a4[4];

      exp_a1 = '{24'h000100, 24'h000104, 24'h000108, 24'h00010C, 24'h000110};
      exp_a4 = '{24'hFFFFF8, 24'hFFFFFC, 24'h000000, 24'h000004};
      reset = 1'b1; start = 1'b0; base_addr = '0; num_samples = '0;
      sdwaitrequest = 1'b0; sample_ready = 1'b0;
      step(2);
      check_reset_outputs("por");
      reset = 1'b0;
      step();

      // Basic fetch
      i0 = issued.size(); g0 = got.size(); d0 = done_cnt;
      sample_ready = 1'b1;
      go(24'h000100, 5);
      check("t1_busy", {31'h0, busy}, 32'h1);
      check("t1_sdread", {31'h0, sdread}, 32'h1);
      check("t1_first_addr", {8'h0, sdaddress}, 32'h100);
      wait_done("t1_done", 60);
      step(3);
      check("t1_nreads", issued.size() - i0, 5);
      check("t1_nsamples", got.size() - g0, 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t1_addr%0d", i), {8'h0, issued[i0+i]}, {8'h0, exp_a1[i]});
         check($sformatf("t1_data%0d", i), got[g0+i], {8'hC3, exp_a1[i]});
      end
      check("t1_received", received_count, 5);
      check("t1_done_pulses", done_cnt - d0, 1);
      check("t1_busy_after", {31'h0, busy}, 32'h0);

      // Backpressure: FIFO plus in-flight reads cap issue at 16
      i0 = issued.size(); g0 = got.size();
      sample_ready = 1'b0;
      go(24'h001000, 40);
      step(100);
      check("t2_reads_capped", issued.size() - i0, 16);
      check("t2_sdread_low", {31'h0, sdread}, 32'h0);
      check("t2_received16", received_count, 16);
      check("t2_valid", {31'h0, sample_valid}, 32'h1);
      sample_ready = 1'b1;
      wait_done("t2_done", 400);
      step(3);
      check("t2_nreads", issued.size() - i0, 40);
      check("t2_nsamples", got.size() - g0, 40);
      for (int i = 0; i < 40; i++)
         check($sformatf("t2_data%0d", i), got[g0+i], 32'hC3001000 + 32'(4*i));
      check("t2_received", received_count, 40);

      // Waitrequest on the second request
      i0 = issued.size();
      go(24'h002000, 4);
      check("t3_addr0", {8'h0, sdaddress}, 32'h2000);
      step();
      sdwaitrequest = 1'b1;
      check("t3_addr1", {8'h0, sdaddress}, 32'h2004);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("t3_hold_addr%0d", k), {8'h0, sdaddress}, 32'h2004);
         check($sformatf("t3_hold_read%0d", k), {31'h0, sdread}, 32'h1);
      end
      sdwaitrequest = 1'b0;
      wait_done("t3_done", 60);
      step(3);
      check("t3_nreads", issued.size() - i0, 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t3_addr_seq%0d", i), {8'h0, issued[i0+i]}, 32'h2000 + 32'(4*i));

      // Address wrap
      i0 = issued.size(); g0 = got.size();
      go(24'hFFFFFA, 4);
      wait_done("t4_done", 60);
      step(3);
      check("t4_nreads", issued.size() - i0, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t4_addr%0d", i), {8'h0, issued[i0+i]}, {8'h0, exp_a4[i]});
         check($sformatf("t4_data%0d", i), got[g0+i], {8'hC3, exp_a4[i]});
      end

      // Zero length
      i0 = issued.size(); d0 = done_cnt;
      go(24'h000500, 0);
      check("t4z_done", {31'h0, done}, 32'h1);
      check("t4z_busy", {31'h0, busy}, 32'h0);
      check("t4z_sdread", {31'h0, sdread}, 32'h0);
      step();
      check("t4z_done_drop", {31'h0, done}, 32'h0);
      step(2);
      check("t4z_noreads", issued.size() - i0, 0);
      check("t4z_pulses", done_cnt - d0, 1);

      // Reset with 3 reads outstanding, then stray returns
      hold = 1'b1;
      go(24'h003000, 3);
      step(4);
      check("t5_drain_busy", {31'h0, busy}, 32'h1);
      check("t5_sdread", {31'h0, sdread}, 32'h0);
      reset = 1'b1;
      step();
      check_reset_outputs("t5_rst");
      reset = 1'b0;
      hold  = 1'b0;
      step(6);
      check("t5_discard", discard_count, 3);
      check("t5_received", received_count, 0);
      check("t5_valid", {31'h0, sample_valid}, 32'h0);
      check("t5_busy", {31'h0, busy}, 32'h0);

      i0 = issued.size(); g0 = got.size();
      go(24'h004000, 2);
      wait_done("t5_refetch_done", 60);
      step(3);
      check("t5_nreads", issued.size() - i0, 2);
      check("t5_addr0", {8'h0, issued[i0]}, 32'h4000);
      check("t5_addr1", {8'h0, issued[i0+1]}, 32'h4004);
      check("t5_data0", got[g0], 32'hC3004000);
      check("t5_data1", got[g0+1], 32'hC3004004);
      check("t5_received2", received_count, 2);
      check("t5_discard_kept", discard_count, 3);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
